// File: rtl/hermes_mesh_noc.sv
// Hermes 2-D mesh NoC: wormhole switching, XY routing, credit flow control.
// Port order inside a router: 0=E, 1=W, 2=N (y+1), 3=S (y-1), 4=LOCAL.

// One mesh router: five input FIFOs, round-robin switch allocation per
// output, and a registered output stage on every output port.
module hermes_router #(
    parameter int X_SIZE      = 4,
    parameter int Y_SIZE      = 4,
    parameter int BUFFER_SIZE = 8,
    parameter int MY_X        = 0,
    parameter int MY_Y        = 0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [4:0]      rx_i,
    input  logic [4:0][31:0] data_i,
    output logic [4:0]      credit_o,
    output logic [4:0]      tx_o,
    output logic [4:0][31:0] data_o,
    input  logic [4:0]      credit_i
);
    localparam int AW = $clog2(BUFFER_SIZE);
    localparam logic [AW:0] FULL = (AW+1)'(BUFFER_SIZE);
    localparam logic [2:0] P_E = 3'd0, P_W = 3'd1, P_N = 3'd2, P_S = 3'd3, P_L = 3'd4;

    // XY routing; a direction without a neighbour falls back to LOCAL.
    function automatic logic [2:0] route(input logic [31:0] h);
        int tx, ty;
        tx = int'(h[15:8]);
        ty = int'(h[7:0]);
        route = P_L;
        if (tx > MY_X)      route = (MY_X < X_SIZE-1) ? P_E : P_L;
        else if (tx < MY_X) route = (MY_X > 0)        ? P_W : P_L;
        else if (ty > MY_Y) route = (MY_Y < Y_SIZE-1) ? P_N : P_L;
        else if (ty < MY_Y) route = (MY_Y > 0)        ? P_S : P_L;
    endfunction

    logic [4:0][BUFFER_SIZE-1:0][31:0] mem_q;
    logic [4:0][AW-1:0] wp_q, rp_q;
    logic [4:0][AW:0]   cnt_q, cnt_d;
    logic [4:0]         cred_q, push, pop, conn;
    logic [4:0][31:0]   head;
    logic [4:0][2:0]    dest;

    logic [4:0]         busy_q, busy_d, tx_q, tx_d;
    logic [4:0][2:0]    own_q, own_d, ptr_q, ptr_d;
    logic [4:0][1:0]    ph_q, ph_d;
    logic [4:0][31:0]   rem_q, rem_d, dat_q, dat_d;

    assign credit_o = cred_q;
    assign tx_o     = tx_q;
    assign data_o   = dat_q;

    // FIFO heads, push qualification, occupancy next-state and route request.
    always_comb begin
        conn = '0;
        for (int o = 0; o < 5; o++)
            if (busy_q[o]) conn[own_q[o]] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            head[i]  = mem_q[i][rp_q[i]];
            push[i]  = rx_i[i] & cred_q[i];
            cnt_d[i] = cnt_q[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
            dest[i]  = route(head[i]);
        end
    end

    // Per output: forward flits of the owning input, or grant a new header.
    always_comb begin
        logic       found, ld;
        logic [2:0] src;
        int         idx;
        busy_d = busy_q;
        own_d  = own_q;
        ptr_d  = ptr_q;
        ph_d   = ph_q;
        rem_d  = rem_q;
        tx_d   = tx_q & ~credit_i;
        dat_d  = dat_q;
        pop    = '0;
        for (int o = 0; o < 5; o++) begin
            ld  = ~tx_q[o] | credit_i[o];
            src = own_q[o];
            if (busy_q[o]) begin
                if (cnt_q[src] != '0 && ld) begin
                    pop[src] = 1'b1;
                    tx_d[o]  = 1'b1;
                    dat_d[o] = head[src];
                    case (ph_q[o])
                        2'd0: ph_d[o] = 2'd1;
                        2'd1: begin
                            // Size flit: N==0 means this is the last flit.
                            if (head[src] == '0) busy_d[o] = 1'b0;
                            rem_d[o] = head[src];
                            ph_d[o]  = 2'd2;
                        end
                        default: begin
                            rem_d[o] = rem_q[o] - 32'd1;
                            if (rem_q[o] == 32'd1) busy_d[o] = 1'b0;
                        end
                    endcase
                end
            end else begin
                found = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    idx = (int'(ptr_q[o]) + k) % 5;
                    if (!found && !conn[idx] && cnt_q[idx] != '0 && dest[idx] == 3'(o)) begin
                        found     = 1'b1;
                        busy_d[o] = 1'b1;
                        own_d[o]  = 3'(idx);
                        ph_d[o]   = 2'd0;
                        ptr_d[o]  = (idx == 4) ? 3'd0 : 3'(idx + 1);
                    end
                end
            end
        end
    end

    // FIFO storage; contents need no reset since pointers are cleared.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 5; i++)
            if (push[i]) mem_q[i][wp_q[i]] <= data_i[i];
    end

    // Control state: pointers, credits, connections, output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            cred_q <= '0;
            busy_q <= '0;
            own_q  <= '0;
            ptr_q  <= '0;
            ph_q   <= '0;
            rem_q  <= '0;
            tx_q   <= '0;
            dat_q  <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (push[i]) wp_q[i] <= wp_q[i] + 1'b1;
                if (pop[i])  rp_q[i] <= rp_q[i] + 1'b1;
                cred_q[i] <= (cnt_d[i] != FULL);
            end
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            own_q  <= own_d;
            ptr_q  <= ptr_d;
            ph_q   <= ph_d;
            rem_q  <= rem_d;
            tx_q   <= tx_d;
            dat_q  <= dat_d;
        end
    end
endmodule

// Mesh top: array of routers with neighbour links; edge links tied off.
module hermes_mesh_noc #(
    parameter int X_SIZE      = 4,
    parameter int Y_SIZE      = 4,
    parameter int BUFFER_SIZE = 8,
    localparam int NUM_ROUTERS = X_SIZE * Y_SIZE
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_ROUTERS-1:0]        rx_i,
    input  logic [NUM_ROUTERS-1:0][31:0]  data_i,
    input  logic [NUM_ROUTERS-1:0]        credit_i,
    output logic [NUM_ROUTERS-1:0]        tx_o,
    output logic [NUM_ROUTERS-1:0][31:0]  data_o,
    output logic [NUM_ROUTERS-1:0]        credit_o
);
    logic [NUM_ROUTERS-1:0][4:0]       ivld, icr, ovld, ocr;
    logic [NUM_ROUTERS-1:0][4:0][31:0] idat, odat;

    for (genvar r = 0; r < NUM_ROUTERS; r++) begin : g_r
        localparam int RX = r % X_SIZE;
        localparam int RY = r / X_SIZE;

        hermes_router #(
            .X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE), .BUFFER_SIZE(BUFFER_SIZE),
            .MY_X(RX), .MY_Y(RY)
        ) u_router (
            .clk_i(clk_i), .rst_i(rst_i),
            .rx_i(ivld[r]), .data_i(idat[r]), .credit_o(icr[r]),
            .tx_o(ovld[r]), .data_o(odat[r]), .credit_i(ocr[r])
        );

        assign ivld[r][4] = rx_i[r];
        assign idat[r][4] = data_i[r];
        assign ocr[r][4]  = credit_i[r];
        assign tx_o[r]     = ovld[r][4];
        assign data_o[r]   = odat[r][4];
        assign credit_o[r] = icr[r][4];

        if (RX < X_SIZE-1) begin : g_e
            assign ivld[r][0] = ovld[r+1][1];
            assign idat[r][0] = odat[r+1][1];
            assign ocr[r][0]  = icr[r+1][1];
        end else begin : g_ne
            logic unused_e;
            assign ivld[r][0] = 1'b0;
            assign idat[r][0] = '0;
            assign ocr[r][0]  = 1'b0;
            assign unused_e   = ovld[r][0] ^ (^odat[r][0]) ^ icr[r][0];
        end

        if (RX > 0) begin : g_w
            assign ivld[r][1] = ovld[r-1][0];
            assign idat[r][1] = odat[r-1][0];
            assign ocr[r][1]  = icr[r-1][0];
        end else begin : g_nw
            logic unused_w;
            assign ivld[r][1] = 1'b0;
            assign idat[r][1] = '0;
            assign ocr[r][1]  = 1'b0;
            assign unused_w   = ovld[r][1] ^ (^odat[r][1]) ^ icr[r][1];
        end

        if (RY < Y_SIZE-1) begin : g_n
            assign ivld[r][2] = ovld[r+X_SIZE][3];
            assign idat[r][2] = odat[r+X_SIZE][3];
            assign ocr[r][2]  = icr[r+X_SIZE][3];
        end else begin : g_nn
            logic unused_n;
            assign ivld[r][2] = 1'b0;
            assign idat[r][2] = '0;
            assign ocr[r][2]  = 1'b0;
            assign unused_n   = ovld[r][2] ^ (^odat[r][2]) ^ icr[r][2];
        end

        if (RY > 0) begin : g_s
            assign ivld[r][3] = ovld[r-X_SIZE][2];
            assign idat[r][3] = odat[r-X_SIZE][2];
            assign ocr[r][3]  = icr[r-X_SIZE][2];
        end else begin : g_ns
            logic unused_s;
            assign ivld[r][3] = 1'b0;
            assign idat[r][3] = '0;
            assign ocr[r][3]  = 1'b0;
            assign unused_s   = ovld[r][3] ^ (^odat[r][3]) ^ icr[r][3];
        end
    end
endmodule

// File: tb/tb_hermes_mesh_noc.sv
// Scoreboard bench for hermes_mesh_noc on a 4x4 mesh with 4-deep FIFOs.
module tb_hermes_mesh_noc;
    localparam int NR = 16;

    logic                 clk = 1'b0;
    logic                 rst_i;
    logic [NR-1:0]        rx_i, credit_i, tx_o, credit_o;
    logic [NR-1:0][31:0]  data_i, data_o;

    int n_vec = 0, n_err = 0, cyc = 0, inj_cyc = 0, stale = 0;
    logic [31:0] exp_q [NR][$];
    int ndel [NR], first_c [NR], last_c [NR];

    hermes_mesh_noc #(.X_SIZE(4), .Y_SIZE(4), .BUFFER_SIZE(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .rx_i(rx_i), .data_i(data_i),
        .credit_i(credit_i), .tx_o(tx_o), .data_o(data_o), .credit_o(credit_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] flit(int k, logic [31:0] hdr, int n, logic [31:0] base, logic [31:0] step);
        if (k == 0) return hdr;
        if (k == 1) return 32'(n);
        return base + 32'(k - 2) * step;
    endfunction

    function automatic int pending();
        int s = 0;
        for (int r = 0; r < NR; r++) s += exp_q[r].size();
        return s;
    endfunction

    // Sink side: every flit handed over at the next edge is checked in order.
    always @(negedge clk) begin
        #1;
        if (!rst_i)
            for (int r = 0; r < NR; r++)
                if (tx_o[r] && credit_i[r]) begin
                    if (exp_q[r].size() == 0) stale++;
                    else chk($sformatf("flit_r%0d_%0d", r, ndel[r]), data_o[r], exp_q[r].pop_front());
                    if (first_c[r] < 0) first_c[r] = cyc + 1;
                    last_c[r] = cyc + 1;
                    ndel[r]++;
                end
    end

    task automatic clr();
        for (int r = 0; r < NR; r++) begin
            ndel[r] = 0; first_c[r] = -1; last_c[r] = -1;
            exp_q[r].delete();
        end
        stale = 0;
    endtask

    task automatic push_pkt(int dst, logic [31:0] hdr, int n, logic [31:0] base, logic [31:0] step);
        for (int k = 0; k < n + 2; k++) exp_q[dst].push_back(flit(k, hdr, n, base, step));
    endtask

    // Source side: valid held with data until credit_o allows the transfer.
    task automatic send(int src, int dst, logic [31:0] hdr, int n, logic [31:0] base,
                        logic [31:0] step, bit do_push);
        logic [31:0] f;
        int w;
        for (int k = 0; k < n + 2; k++) begin
            f = flit(k, hdr, n, base, step);
            @(negedge clk);
            if (rst_i) break;
            rx_i[src] = 1'b1;
            data_i[src] = f;
            w = 0;
            while (!credit_o[src] && !rst_i && w < 2000) begin
                @(negedge clk);
                w++;
            end
            if (rst_i) break;
            if (w >= 2000) begin
                chk("inj_timeout", 32'(w), 32'd0);
                break;
            end
            if (do_push) exp_q[dst].push_back(f);
            if (k == 0) inj_cyc = cyc + 1;
        end
        if (!rst_i) @(negedge clk);
        rx_i[src] = 1'b0;
    endtask

    task automatic drain(string tag, int bound);
        int c = 0;
        while (pending() > 0 && c < bound) begin
            @(negedge clk);
            c++;
        end
        repeat (5) @(negedge clk);
        chk({tag, "_drain"}, 32'(pending()), 32'd0);
        chk({tag, "_stale"}, 32'(stale), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_i = 1'b1; rx_i = '0; data_i = '0; credit_i = '1;
        clr();

        // Reset behaviour
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_tx", 32'(tx_o), 32'd0);
        chk("rst_data", 32'(|data_o), 32'd0);
        chk("rst_credit", 32'(credit_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk); #1;
        chk("rel_credit", 32'(credit_o), 32'h0000_FFFF);

        // Corner to corner, 6 hops
        clr();
        send(0, 15, 32'h0000_0303, 4, 32'h11, 32'h11, 1'b1);
        drain("p2", 300);
        chk("p2_lat", 32'(first_c[15] - inj_cyc), 32'd21);
        chk("p2_contig", 32'(last_c[15] - first_c[15]), 32'd5);
        chk("p2_cnt", 32'(ndel[15]), 32'd6);

        // Self-addressed, N=0
        clr();
        send(5, 5, 32'h0101_0101, 0, 32'h0, 32'h0, 1'b1);
        drain("p3", 100);
        chk("p3_lat_le6", 32'((first_c[5] - inj_cyc) <= 6), 32'd1);
        chk("p3_cnt", 32'(ndel[5]), 32'd2);

        // Target y beyond the mesh: goes to x=2, climbs to top row, ejects at router 14
        clr();
        send(0, 14, 32'h0000_0209, 2, 32'hA0, 32'h1, 1'b1);
        drain("edge", 200);
        chk("edge_lat", 32'(first_c[14] - inj_cyc), 32'd18);
        chk("edge_cnt", 32'(ndel[14]), 32'd4);

        // Contention at router 1: east input (from router 2) wins first
        clr();
        push_pkt(1, 32'h0200_0100, 10, 32'h2000, 32'h1);
        push_pkt(1, 32'h0000_0100, 10, 32'h1000, 32'h1);
        fork
            send(0, 1, 32'h0000_0100, 10, 32'h1000, 32'h1, 1'b0);
            send(2, 1, 32'h0200_0100, 10, 32'h2000, 32'h1, 1'b0);
        join
        drain("cont", 300);
        chk("cont_cnt", 32'(ndel[1]), 32'd24);
        chk("cont_span_ge24", 32'((last_c[1] - first_c[1] + 1) >= 24), 32'd1);

        // Backpressure at router 15 local sink
        clr();
        @(negedge clk);
        credit_i[15] = 1'b0;
        fork
            send(0, 15, 32'h0000_0303, 40, 32'h5000, 32'h3, 1'b1);
            begin
                w = 0;
                while (credit_o[0] && w < 400) begin
                    @(negedge clk);
                    w++;
                end
                chk("bp_credit0", 32'(credit_o[0]), 32'd0);
                repeat (10) @(negedge clk);
                credit_i[15] = 1'b1;
            end
        join
        drain("bp", 400);
        chk("bp_cnt", 32'(ndel[15]), 32'd42);

        // Reset in the middle of a packet
        clr();
        fork
            send(0, 15, 32'h0000_0303, 20, 32'h7000, 32'h1, 1'b1);
            begin
                repeat (12) @(negedge clk);
                rst_i = 1'b1;
            end
        join
        #1;
        chk("mid_rst_tx", 32'(tx_o), 32'd0);
        chk("mid_rst_credit", 32'(credit_o), 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        clr();
        repeat (40) @(negedge clk);
        chk("mid_rst_stale", 32'(stale), 32'd0);
        send(0, 15, 32'h0000_0303, 3, 32'h9000, 32'h1, 1'b1);
        drain("post_rst", 200);
        chk("post_rst_cnt", 32'(ndel[15]), 32'd5);
        chk("post_rst_lat", 32'(first_c[15] - inj_cyc), 32'd21);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
